// File: rtl/mdu_iter_pkg.sv
// Shared multiply/divide unit definitions.
// Holds the MDU_* operation codes driven by the decoder, the unit's
// state encoding, and a small decode helper used by the datapath.
package mdu_iter_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_S_IDLE = 2'd0,
    MDU_S_MUL  = 2'd1,
    MDU_S_DIV  = 2'd2,
    MDU_S_FIX  = 2'd3
  } mdu_state_e;

  // Signed flavour of multiply, divide and multiply-accumulate ops.
  function automatic logic mdu_op_signed(mdu_op_e op);
    return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
  endfunction

endpackage

// File: rtl/mdu_iter_div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem_i     current partial remainder (always < divisor_i)
//   divisor_i unsigned divisor magnitude
//   bit_i     next dividend bit, MSB first
//   rem_o     new partial remainder
//   q_o       quotient bit produced by this iteration
module mdu_div_step
  #(parameter int unsigned WIDTH = 32)
  (input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // shifted < 2*divisor, so a non-negative difference always fits in
  // WIDTH bits and bit WIDTH of diff acts as the borrow.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the E stage; owns HI/LO.
// Ports:
//   clk, reset (async, active low)
//   start/kill/op/rs/rt  E-stage request; kill suppresses a same-cycle start
//   busy  operation in flight (stall controller holds on busy||start)
//   done  one-cycle pulse the cycle after HI/LO commit
//   hi/lo architectural HI/LO registers, no bypass
module mdu_iter
  import mdu_iter_pkg::*;
  #(parameter int unsigned WIDTH        = 32,
    parameter int unsigned MUL_CYCLES   = 5,
    parameter int unsigned SUPPORT_MACC = 1)
  (input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             kill,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo);

  localparam int unsigned CNT_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(WIDTH - 1);

  mdu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic                 q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;

  mdu_op_e              op_e;
  logic                 accept, is_signed, a_neg, b_neg;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod, hilo;
  logic [WIDTH-1:0]     a_abs, b_abs, step_rem;
  logic                 step_q;

  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    op_e      = mdu_op_e'(op);
    accept    = start && !kill && (state_q == MDU_S_IDLE);
    is_signed = mdu_op_signed(op_e);
    // Low 2*WIDTH bits of the extended product equal the signed or
    // unsigned full product, so one multiplier serves both flavours.
    ext_a     = is_signed ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
    ext_b     = is_signed ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
    prod      = ext_a * ext_b;
    hilo      = {hi_q, lo_q};
    a_neg     = is_signed & rs[WIDTH-1];
    b_neg     = is_signed & rt[WIDTH-1];
    a_abs     = a_neg ? -rs : rs;
    b_abs     = b_neg ? -rt : rt;

    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    acc_d   = acc_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;

    unique case (state_q)
      MDU_S_IDLE: begin
        if (accept) begin
          unique case (op_e)
            MDU_MULT, MDU_MULTU: begin
              acc_d   = prod;
              cnt_d   = MUL_CNT;
              state_d = MDU_S_MUL;
            end
            MDU_MADD, MDU_MADDU: begin
              if (SUPPORT_MACC != 0) begin
                acc_d   = hilo + prod;
                cnt_d   = MUL_CNT;
                state_d = MDU_S_MUL;
              end
            end
            MDU_MSUB, MDU_MSUBU: begin
              if (SUPPORT_MACC != 0) begin
                acc_d   = hilo - prod;
                cnt_d   = MUL_CNT;
                state_d = MDU_S_MUL;
              end
            end
            MDU_DIV, MDU_DIVU: begin
              dvd_d   = a_abs;
              dvs_d   = b_abs;
              rem_d   = '0;
              q_neg_d = a_neg ^ b_neg;
              r_neg_d = a_neg;
              dz_d    = (rt == '0);
              cnt_d   = DIV_CNT;
              state_d = (rt == '0) ? MDU_S_FIX : MDU_S_DIV;
            end
            MDU_MTHI: begin
              hi_d   = rs;
              done_d = 1'b1;
            end
            MDU_MTLO: begin
              lo_d   = rs;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MDU_S_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = acc_q;
          state_d      = MDU_S_IDLE;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MDU_S_DIV: begin
        // Quotient bits shift into the dividend register as dividend
        // bits shift out, so it holds |quotient| after WIDTH steps.
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        if (cnt_q == '0) state_d = MDU_S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MDU_S_FIX: begin
        if (!dz_q) begin
          lo_d = q_neg_q ? -dvd_q : dvd_q;
          hi_d = r_neg_q ? -rem_q : rem_q;
        end
        state_d = MDU_S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = MDU_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MDU_S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q != MDU_S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter at default parameters.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned MC = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] rs = '0;
  logic [W-1:0] rt = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W), .MUL_CYCLES(MC), .SUPPORT_MACC(1)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .op(op),
    .rs(rs), .rt(rt), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [63:0] hilo;
    int unsigned busy_cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  // Drive one request, update the reference HI/LO, then watch the DUT.
  task automatic apply(input mdu_op_e o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit k, input string tag);
    longint      sa, sb, q, r;
    logic [63:0] p;
    bit          expect_done;
    bit          got;
    int unsigned bc, bcnt;
    exp_t        e;
    expect_done = 0;
    bc = 0;
    sa = $signed(a);
    sb = $signed(b);
    if (!k) begin
      case (o)
        MDU_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; expect_done = 1; bc = MC; end
        MDU_MULTU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; expect_done = 1; bc = MC; end
        MDU_MADD:  begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; expect_done = 1; bc = MC; end
        MDU_MADDU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = {m_hi, m_lo} + p; expect_done = 1; bc = MC; end
        MDU_MSUB:  begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} - p; expect_done = 1; bc = MC; end
        MDU_MSUBU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = {m_hi, m_lo} - p; expect_done = 1; bc = MC; end
        MDU_DIV, MDU_DIVU: begin
          expect_done = 1;
          if (b == '0) bc = 1;
          else begin
            bc = W + 1;
            if (o == MDU_DIVU) begin
              sa = longint'({32'b0, a});
              sb = longint'({32'b0, b});
            end
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
          end
        end
        MDU_MTHI: begin m_hi = a; expect_done = 1; end
        MDU_MTLO: begin m_lo = a; expect_done = 1; end
        default: ;
      endcase
    end
    if (expect_done) exp_q.push_back('{tag, {m_hi, m_lo}, bc});

    @(negedge clk);
    start = 1'b1; kill = k; op = o; rs = a; rt = b;
    @(negedge clk);
    kill = 1'b0; rs = $urandom; rt = $urandom;
    got = 0; bcnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (busy) bcnt++;
      if (done) begin got = 1; break; end
      // Requests while busy must be ignored.
      if (busy) begin start = 1'b1; op = 4'($urandom_range(0, 12)); rs = $urandom; end
      else start = 1'b0;
      if (!expect_done && c >= 3) break;
      @(negedge clk);
    end
    start = 1'b0;

    if (expect_done) begin
      if (got) begin
        check({tag, "_sb"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({e.tag, "_hilo"}, {hi, lo}, e.hilo);
          check({e.tag, "_busy"}, 64'(bcnt), 64'(e.busy_cyc));
        end
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
      end else begin
        check({tag, "_timeout"}, 64'(got), 64'd1);
        exp_q.delete();
      end
    end else begin
      check({tag, "_nodone"}, 64'(got), 64'd0);
      check({tag, "_busy"}, 64'(bcnt), 64'd0);
      check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    end
  endtask

  initial begin
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    apply(MDU_MULT,  32'hFFFF_FFFD, 32'd7, 0, "mult_neg");
    apply(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    apply(MDU_DIVU,  32'hFFFF_FFFF, 32'h10, 0, "divu");
    apply(MDU_DIV,   32'd7, 32'hFFFF_FFFE, 0, "div_negdiv");
    apply(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    apply(MDU_DIVU,  32'd3, 32'd10, 0, "divu_small");
    apply(MDU_MTHI,  32'd5, 32'd0, 0, "mthi");
    apply(MDU_MTLO,  32'd9, 32'd0, 0, "mtlo");
    apply(MDU_DIVU,  32'd123, 32'd0, 0, "div_zero");
    apply(MDU_MULT,  32'd2, 32'd3, 1, "kill_mult");
    apply(MDU_MTLO,  32'h55, 32'd0, 1, "kill_mtlo");
    apply(MDU_MFHI,  32'h77, 32'd1, 0, "mfhi");
    apply(MDU_NOP,   32'h77, 32'd1, 0, "nop");
    apply(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 0, "multu");
    apply(MDU_MADDU, 32'd1, 32'd1, 0, "maddu");
    apply(MDU_MSUB,  32'd1, 32'd2, 0, "msub");

    // Asynchronous reset ten cycles into a divide.
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; rs = 32'd1000; rt = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    apply(MDU_MULT, 32'd6, 32'd7, 0, "post_rst");

    for (int i = 0; i < 24; i++) begin
      mdu_op_e     ro;
      logic [W-1:0] ra, rb;
      ro = mdu_op_e'($urandom_range(0, 12));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (ro inside {MDU_DIV, MDU_DIVU} && $urandom_range(0, 5) == 0) rb = '0;
      apply(ro, ra, rb, ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised successor to the pipeline's fixed-latency multiply/divide unit.
- Sits in the E stage and owns the HI/LO registers.
- The multiplier has a configurable latency; the divider is a true radix-2 restoring iterative divider (WIDTH cycles).
- Adds multiply-accumulate ops, a same-cycle kill for flushed E-stage instructions, and a done pulse for the stall controller.

Parameters:
- WIDTH, 32: operand and HI/LO width. Must be even and at least 8.
- MUL_CYCLES, 5: busy cycles for MULT/MULTU/MADD*/MSUB*. Must be at least 1.
- SUPPORT_MACC, 1: 1 enables MADD/MADDU/MSUB/MSUBU; 0 decodes them as NOP.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage op valid; sampled on the rising edge.
- kill  in  1  flush of the current E-stage instruction; suppresses a same-cycle start.
- op  in  4  operation code, MDU_* from the shared package.
- rs  in  WIDTH  operand A (forwarded value).
- rt  in  WIDTH  operand B (forwarded value).
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle pulse in the cycle after HI/LO commit.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, all internal operand registers 0. Reset mid-operation discards the op; HI/LO are 0 after reset is released.
- Accept: start && !kill && state==IDLE. A start while busy is ignored; the stall controller must hold the pipeline on busy||start. A start with kill=1 has no effect at all, including MTHI/MTLO.
- MTHI/MTLO: HI (or LO) <= rs at the accepting edge. busy stays 0; done=1 in the next cycle.
- MFHI/MFLO and NOP op codes: accepted, no state change, no done.
- States: IDLE, MUL, DIV, FIX.
- MUL path:
  - At the accept edge the full 2*WIDTH product is registered: signed for MULT/MADD/MSUB, unsigned for the U variants.
  - For MADD* the target is {HI,LO}+product; for MSUB* it is {HI,LO}-product; both modulo 2^(2*WIDTH) using the HI/LO values at accept time.
  - cnt <= MUL_CYCLES-1, state MUL, busy=1.
  - Each edge in MUL: if cnt==0, commit {HI,LO}, go to IDLE, busy=0, done=1 next cycle; else cnt--.
  - busy is therefore high for exactly MUL_CYCLES cycles.
- DIV path:
  - At accept: latch |rs|, |rt|, sign of quotient and sign of remainder (signed ops only), clear the partial remainder, cnt <= WIDTH-1, state DIV.
  - Each DIV edge produces one quotient bit, MSB first: shift the remainder left with the next dividend bit, subtract the divisor if it is not negative.
  - When cnt==0, go to FIX.
  - FIX (1 cycle): apply the signs. Quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs) (truncating division). Write LO=quotient, HI=remainder, go to IDLE, done=1 next cycle.
  - busy is high for WIDTH+1 cycles: 33 at the default.
- Divide by zero (rt==0 at accept): no iteration; state FIX for one cycle, HI/LO left unchanged, done still pulses. busy is high for 1 cycle.
- Overflow: signed -2^(WIDTH-1) / -1 gives LO=-2^(WIDTH-1), HI=0 (natural wrap). This is not an exception.
- Operands are captured at accept. Changes on rs/rt while busy have no effect.
- hi/lo are direct register outputs with no bypass. A reader must wait for !busy.
- done and a new accept may coincide: the next op may be accepted in the done cycle.

Decomposition:
- Shared package (same file as the existing MDU_* constants):
  - op codes MDU_NOP, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU;
  - state encoding MDU_S_IDLE, MDU_S_MUL, MDU_S_DIV, MDU_S_FIX.
- One sub-module, mdu_div_step: purely combinational single restoring iteration (remainder, divisor, next bit -> new remainder, quotient bit), instantiated once.

Test Plan:
- Multiply: MULT rs=-3, rt=7, MUL_CYCLES=5 -> busy high for 5 cycles, then {HI,LO}=0xFFFFFFFF_FFFFFFEB, done pulses once.
- Divide: DIV rs=-7, rt=2 -> busy high for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0xFFFFFFFF/0x10 -> LO=0x0FFFFFFF, HI=0xF.
- Divide by zero: HI=5, LO=9 preset via MTHI/MTLO, then DIVU rt=0 -> HI=5, LO=9 unchanged, busy high 1 cycle, done pulses.
- Kill: start+kill with MULT 2*3 and with MTLO 0x55 -> busy stays 0, HI/LO unchanged, no done.
- Multiply-accumulate: MULTU 0xFFFFFFFF*2, then MADDU 1*1 -> {HI,LO}=0x00000001_FFFFFFFF. Then MSUB 1*2 -> 0x00000001_FFFFFFFD.
- Reset mid-divide: assert reset 10 cycles into a DIV -> busy=0, HI=LO=0 immediately (asynchronous). A start after reset release completes normally.
